// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues word-aligned imem requests under
// a credit limit, buffers returned words with their PCs and hands them to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];

  logic            credit_s, accept_s, rsp_s, drop_s, push_s, pop_s, empty_s;
  logic [31:0]     target_s;

  // In-flight plus buffered words never exceed DEPTH, so a response always has a slot.
  assign credit_s       = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_W;
  assign imem_req_valid = !rst && credit_s && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign rsp_s          = imem_rsp_valid && !rst && (out_q != {CW{1'b0}});
  assign drop_s         = rsp_s && (redirect_valid || (state_q == FLUSH));
  assign push_s         = rsp_s && !drop_s;
  assign empty_s        = (cnt_q == {CW{1'b0}});
  assign inst_valid     = !empty_s && !redirect_valid;
  assign pop_s          = inst_valid && inst_ready;
  assign target_s       = redirect_pc & 32'hFFFF_FFFC;

  // Head-of-FIFO presentation; NOP and PC 0 while nothing is buffered.
  always_comb begin
    inst    = NOP;
    inst_pc = 32'h0000_0000;
    if (!empty_s) begin
      inst    = mem_inst_q[rd_ptr_q];
      inst_pc = mem_pc_q[rd_ptr_q];
    end else begin
      inst    = NOP;
      inst_pc = 32'h0000_0000;
    end
  end

  // Next-state for PCs, credit counters, FIFO pointers and the RUN/FLUSH state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = target_s;
      rsp_pc_d   = target_s;
      out_d      = out_q - CW'(rsp_s);
      disc_d     = out_q - CW'(rsp_s);
      cnt_d      = {CW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
    end else begin
      if (accept_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      out_d = out_q + CW'(accept_s) - CW'(rsp_s);
      if (drop_s) begin
        disc_d = disc_q - CW'(1'b1);
      end else begin
        disc_d = disc_q;
      end
      if (push_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        rsp_pc_d = rsp_pc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
    end
    state_d = (disc_d != {CW{1'b0}}) ? FLUSH : RUN;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= {CW{1'b0}};
      disc_q     <= {CW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_inst_q[wr_ptr_q] <= imem_rsp_data;
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order imem model; responses can be
// held back to build up outstanding requests around redirects.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic        st_rst, st_redir, st_qrdy, st_irdy, st_stall;
  logic [31:0] st_rpc;
  logic        s_rst, s_rv, s_acc, s_rsp, s_iv, s_pop;
  logic [31:0] s_addr, s_inst, s_ipc;
  logic [31:0] exp_pc, exp_addr;
  logic [31:0] imem_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: retire the previous edge in the imem model, apply staged inputs, sample mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (s_rst) begin
      imem_q.delete();
    end else begin
      if (s_rsp) void'(imem_q.pop_front());
      if (s_acc) imem_q.push_back(s_addr);
    end
    rst            = st_rst;
    redirect_valid = st_redir;
    redirect_pc    = st_rpc;
    imem_req_ready = st_qrdy;
    inst_ready     = st_irdy;
    if (!st_rst && !st_stall && imem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = imem_q[0] + OFS;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end
    @(negedge clk);
    s_rst  = rst;
    s_rv   = imem_req_valid;
    s_acc  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_rsp  = imem_rsp_valid;
    s_iv   = inst_valid;
    s_pop  = inst_valid && inst_ready;
    s_inst = inst;
    s_ipc  = inst_pc;
  endtask

  // Cycle plus in-order checks on every accepted request and every consumed instruction.
  task automatic cyc_chk();
    cyc();
    if (s_acc) begin
      chk("req_addr", s_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (s_pop) begin
      chk("inst_pc", s_ipc, exp_pc);
      chk("inst", s_inst, exp_pc + OFS);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    inst_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    st_rst = 1'b1; st_redir = 1'b0; st_rpc = 32'h0; st_qrdy = 1'b0; st_irdy = 1'b0; st_stall = 1'b0;
    s_rst = 1'b1; s_rsp = 1'b0; s_acc = 1'b0; s_addr = 32'h0;
    exp_pc = 32'h0; exp_addr = 32'h0;

    // Reset state
    cyc(); cyc();
    chk("rst_req_valid", s_rv, 1'b0);
    chk("rst_req_addr", s_addr, 32'h0000_0000);
    chk("rst_inst_valid", s_iv, 1'b0);
    chk("rst_inst", s_inst, NOP);
    chk("rst_inst_pc", s_ipc, 32'h0);

    // Streaming from reset, first instruction two cycles after first accept
    st_rst = 1'b0; st_qrdy = 1'b1; st_irdy = 1'b1;
    cyc_chk(); chk("first_accept", s_acc, 1'b1); chk("c0_iv", s_iv, 1'b0);
    cyc_chk(); chk("c1_iv", s_iv, 1'b0);
    cyc_chk(); chk("first_valid", s_iv, 1'b1); chk("first_pc", s_ipc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc_chk(); chk("steady_iv", s_iv, 1'b1);
    end

    // Decode stall: FIFO fills and the credit limit stops requests
    st_irdy = 1'b0;
    for (int i = 0; i < 6; i++) cyc_chk();
    chk("full_req_valid", s_rv, 1'b0);
    chk("full_inst_valid", s_iv, 1'b1);
    st_irdy = 1'b1;
    for (int i = 0; i < 10; i++) cyc_chk();
    st_irdy = 1'b0;
    for (int i = 0; i < 6; i++) cyc_chk();
    chk("refull_req_valid", s_rv, 1'b0);

    // Reset with FIFO full, then imem stall at 0x8
    st_rst = 1'b1;
    cyc();
    st_rst = 1'b0; st_irdy = 1'b1; exp_pc = 32'h0; exp_addr = 32'h0;
    cyc_chk();
    chk("post_rst_iv", s_iv, 1'b0);
    chk("post_rst_inst", s_inst, NOP);
    chk("post_rst_addr", s_addr, 32'h0000_0000);
    chk("post_rst_acc", s_acc, 1'b1);
    cyc_chk();
    st_qrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_chk();
      chk("stall_req_valid", s_rv, 1'b1);
      chk("stall_addr", s_addr, 32'h0000_0008);
    end
    st_qrdy = 1'b1;
    cyc_chk(); chk("resume_acc", s_acc, 1'b1);
    for (int i = 0; i < 4; i++) cyc_chk();

    // Redirect with two outstanding and one buffered
    st_rst = 1'b1; st_irdy = 1'b0;
    cyc();
    st_rst = 1'b0; exp_pc = 32'h0; exp_addr = 32'h0;
    cyc_chk();
    cyc_chk();
    st_stall = 1'b1;
    cyc_chk(); chk("p2_acc", s_acc, 1'b1);
    st_redir = 1'b1; st_rpc = 32'h0000_0103;
    cyc_chk();
    chk("redir_no_req", s_rv, 1'b0);
    chk("redir_iv", s_iv, 1'b0);
    exp_pc = 32'h0000_0100; exp_addr = 32'h0000_0100;
    st_redir = 1'b0; st_stall = 1'b0; st_irdy = 1'b1;
    cyc_chk();
    chk("redir_new_acc", s_acc, 1'b1);
    chk("redir_new_addr", s_addr, 32'h0000_0100);
    chk("p4_iv", s_iv, 1'b0);
    cyc_chk(); chk("p5_iv", s_iv, 1'b0);
    cyc_chk(); chk("p6_iv", s_iv, 1'b0);
    cyc_chk(); chk("p7_iv", s_iv, 1'b1); chk("p7_pc", s_ipc, 32'h0000_0100);
    for (int i = 0; i < 6; i++) cyc_chk();

    // Redirect coinciding with a response, two outstanding
    st_rst = 1'b1;
    cyc();
    st_rst = 1'b0; exp_pc = 32'h0; exp_addr = 32'h0;
    cyc_chk();
    st_stall = 1'b1;
    cyc_chk(); chk("q1_acc", s_acc, 1'b1);
    st_stall = 1'b0; st_qrdy = 1'b0; st_redir = 1'b1; st_rpc = 32'h0000_0200;
    cyc_chk();
    chk("q2_no_req", s_rv, 1'b0);
    chk("q2_iv", s_iv, 1'b0);
    exp_pc = 32'h0000_0200; exp_addr = 32'h0000_0200;
    st_redir = 1'b0; st_qrdy = 1'b1;
    cyc_chk(); chk("q3_acc", s_acc, 1'b1); chk("q3_iv", s_iv, 1'b0);
    cyc_chk(); chk("q4_iv", s_iv, 1'b0);
    cyc_chk(); chk("q5_iv", s_iv, 1'b1); chk("q5_pc", s_ipc, 32'h0000_0200);
    for (int i = 0; i < 4; i++) cyc_chk();

    // Redirect to the top of the address space; fetch wraps to 0
    st_redir = 1'b1; st_rpc = 32'hFFFF_FFFF;
    cyc_chk();
    st_redir = 1'b0; exp_pc = 32'hFFFF_FFFC; exp_addr = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) cyc_chk();
    chk("wrap_iv", s_iv, 1'b1);
    chk("wrap_pc", s_ipc, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) cyc_chk();
    chk("wrap_next_pc", exp_pc[31:16], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
